// File: rtl/wire_mac_pkg.sv
// Shared definitions for the wire-driven multiply-accumulate engine:
// FSM state encoding, control/status bit positions and a status packer.
package wire_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } mac_state_t;

    // Control word bit positions (WireIn 0x00)
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_MODE  = 2;

    // Status word bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    // Assemble the status word; every bit not named here reads zero.
    function automatic logic [15:0] pack_status(
        input logic       busy,
        input logic       done,
        input logic       ovf,
        input logic [7:0] op_count
    );
        logic [15:0] word;
        word                     = 16'h0000;
        word[STAT_BUSY]          = busy;
        word[STAT_DONE]          = done;
        word[STAT_OVF]           = ovf;
        word[STAT_CNT_LSB +: 8]  = op_count;
        return word;
    endfunction

endpackage

// File: rtl/wire_rise_detect.sv
// Registered rising-edge detector for a level-driven control bit.
// After reset the detector stays disarmed until the input has been seen low,
// so a level that was already high across reset never produces an event.
module wire_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev_r;
    logic armed_r;

    // Track the previous level and arm once the input has been observed low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r  <= sig;
            armed_r <= armed_r | ~sig;
        end
    end

    // One-cycle pulse on each genuine 0->1 transition.
    assign rise = sig & ~prev_r & armed_r;

endmodule

// File: rtl/wire_mac_engine.sv
// Multiply-accumulate engine controlled through host wires.
// A start edge latches the operands, a sequential shift-add multiplier runs
// for OP_W cycles, then the product is accumulated (mode 0) or loaded
// (mode 1) into a 2*OP_W accumulator. A clear edge aborts and zeroes state.
// res_hi maps accumulator bits 31:16, so OP_W is expected to be at least 16.
module wire_mac_engine
    import wire_mac_pkg::*;
#(
    parameter int OP_W = 16
) (
    input  logic            ti_clk,
    input  logic            ti_rst_n,
    input  logic [15:0]     ctrl_in,
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    output logic [15:0]     res_lo,
    output logic [15:0]     res_hi,
    output logic [15:0]     status
);

    localparam int ACC_W = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OP_W - 1);

    mac_state_t        state_r;
    logic [ACC_W-1:0]  mcand_r;
    logic [OP_W-1:0]   mplier_r;
    logic [ACC_W-1:0]  prod_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              mode_r;
    logic [ACC_W-1:0]  acc_r;
    logic              ovf_r;
    logic              done_r;
    logic              busy_r;
    logic [7:0]        op_cnt_r;

    logic              start_s;
    logic              clear_s;
    logic [ACC_W-1:0]  partial_s;
    logic [ACC_W:0]    sum_s;
    logic              unused_ctrl_s;

    // Upper control bits carry no function.
    assign unused_ctrl_s = ^ctrl_in[15:3];

    wire_rise_detect u_start_det (
        .clk   (ti_clk),
        .rst_n (ti_rst_n),
        .sig   (ctrl_in[CTRL_START]),
        .rise  (start_s)
    );

    wire_rise_detect u_clear_det (
        .clk   (ti_clk),
        .rst_n (ti_rst_n),
        .sig   (ctrl_in[CTRL_CLEAR]),
        .rise  (clear_s)
    );

    // Shift-add step and accumulate sum with carry-out.
    always_comb begin
        partial_s = prod_r;
        if (mplier_r[0]) begin
            partial_s = prod_r + mcand_r;
        end else begin
            partial_s = prod_r;
        end
        sum_s = {1'b0, acc_r} + {1'b0, prod_r};
    end

    // Control FSM plus multiply datapath; clear overrides any pending start.
    always_ff @(posedge ti_clk or negedge ti_rst_n) begin
        if (!ti_rst_n) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {ACC_W{1'b0}};
            mplier_r  <= {OP_W{1'b0}};
            prod_r    <= {ACC_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            mode_r    <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            op_cnt_r  <= 8'd0;
        end else if (clear_s) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {ACC_W{1'b0}};
            mplier_r  <= {OP_W{1'b0}};
            prod_r    <= {ACC_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            mode_r    <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            op_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        mcand_r   <= {{OP_W{1'b0}}, op_a};
                        mplier_r  <= op_b;
                        prod_r    <= {ACC_W{1'b0}};
                        bit_cnt_r <= {CNT_W{1'b0}};
                        mode_r    <= ctrl_in[CTRL_MODE];
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_MUL;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    prod_r    <= partial_s;
                    mcand_r   <= mcand_r << 1;
                    mplier_r  <= mplier_r >> 1;
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= ST_ACC;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_ACC: begin
                    if (mode_r) begin
                        acc_r <= prod_r;
                    end else begin
                        acc_r <= sum_s[ACC_W-1:0];
                        ovf_r <= sum_s[ACC_W];
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done_r   <= 1'b1;
                    op_cnt_r <= op_cnt_r + 8'd1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_lo = acc_r[15:0];
    assign res_hi = acc_r[31:16];
    assign status = pack_status(busy_r, done_r, ovf_r, op_cnt_r);

endmodule

// File: tb/tb_wire_mac_engine.sv
// Directed scoreboard bench for wire_mac_engine.
module tb_wire_mac_engine;

    logic        clk;
    logic        rst_n;
    logic [15:0] ctrl_in;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic [15:0] status;

    int errors;
    int checks;

    typedef struct {
        logic [31:0] res;
        logic [15:0] stat;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_acc;
    logic        m_ovf;
    logic [7:0]  m_cnt;

    wire_mac_engine #(.OP_W(16)) dut (
        .ti_clk   (clk),
        .ti_rst_n (rst_n),
        .ctrl_in  (ctrl_in),
        .op_a     (op_a),
        .op_b     (op_b),
        .res_lo   (res_lo),
        .res_hi   (res_hi),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_acc = 32'h0;
        m_ovf = 1'b0;
        m_cnt = 8'h0;
    endtask

    // Run one operation; expectations are pushed when start is driven and
    // popped once busy drops.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic mode,
                          input bit retrig, input bit perturb, input bit keep_start);
        logic [31:0] prod;
        logic [32:0] sum;
        logic [31:0] pre_acc;
        exp_t        e;
        int          c;
        pre_acc = m_acc;
        op_a    = a;
        op_b    = b;
        ctrl_in = {13'h1555, mode, 1'b0, 1'b1};
        prod = {16'h0000, a} * {16'h0000, b};
        sum  = {1'b0, m_acc} + {1'b0, prod};
        if (mode == 1'b0) begin
            m_acc = sum[31:0];
            m_ovf = sum[32];
        end else begin
            m_acc = prod;
        end
        m_cnt  = m_cnt + 8'd1;
        e.res  = m_acc;
        e.stat = {m_cnt, 5'b00000, m_ovf, 1'b1, 1'b0};
        sb_q.push_back(e);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            c = i;
            if (perturb && i == 3) begin
                op_a       = ~a;
                op_b       = ~b;
                ctrl_in[2] = ~mode;
            end
            if (retrig && i == 3) ctrl_in[0] = 1'b0;
            if (retrig && i == 5) ctrl_in[0] = 1'b1;
            if (i == 17) check("res_hold_mul", {res_hi, res_lo}, pre_acc);
            if (i == 18) begin
                check("res_at_k17", {res_hi, res_lo}, e.res);
                check("busy_in_done", {31'h0, status[0]}, 32'h1);
                check("done_cleared", {31'h0, status[1]}, 32'h0);
            end
            if (status[0] == 1'b0) break;
        end
        check("busy_latency", c, 19);
        e = sb_q.pop_front();
        check("result", {res_hi, res_lo}, e.res);
        check("status", {16'h0, status}, {16'h0, e.stat});
        if (!keep_start) begin
            ctrl_in[0] = 1'b0;
            tick();
        end
    endtask

    task automatic do_clear();
        ctrl_in[1] = 1'b1;
        tick();
        check("clear_res", {res_hi, res_lo}, 32'h0);
        check("clear_status", {16'h0, status}, 32'h0);
        ctrl_in[1] = 1'b0;
        tick();
        model_zero();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        ctrl_in = 16'h0000;
        op_a    = 16'h0000;
        op_b    = 16'h0000;
        model_zero();
        repeat (2) tick();
        check("rst_res_lo", {16'h0, res_lo}, 32'h0);
        check("rst_res_hi", {16'h0, res_hi}, 32'h0);
        check("rst_status", {16'h0, status}, 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 3 * 5 accumulate
        run_op(16'd3, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r030_lo", {16'h0, res_lo}, 32'h0000000F);
        check("r030_hi", {16'h0, res_hi}, 32'h0);
        check("r030_status", {16'h0, status}, 32'h00000102);
        do_clear();

        // Full-scale operands twice: second accumulate carries out
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r031_first", {res_hi, res_lo}, 32'hFFFE0001);
        check("r031_ovf0", {31'h0, status[2]}, 32'h0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("r031_second", {res_hi, res_lo}, 32'hFFFC0002);
        check("r031_ovf1", {31'h0, status[2]}, 32'h1);
        check("r031_cnt", {24'h0, status[15:8]}, 32'h2);

        // Load mode keeps overflow
        run_op(16'd2, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("r032_load", {res_hi, res_lo}, 32'h00000006);
        check("r032_ovf", {31'h0, status[2]}, 32'h1);
        do_clear();

        // Operand/mode changes mid-flight are ignored
        run_op(16'h1234, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Second start edge during MUL, then start held high
        run_op(16'h0101, 16'h0202, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (40) tick();
        check("hold_start_busy", {31'h0, status[0]}, 32'h0);
        check("hold_start_status", {16'h0, status}, {16'h0, m_cnt, 5'b00000, m_ovf, 1'b1, 1'b0});
        check("hold_start_res", {res_hi, res_lo}, m_acc);
        ctrl_in[0] = 1'b0;
        tick();

        // Clear edge at MUL cycle 8
        op_a = 16'd9;
        op_b = 16'd9;
        ctrl_in[0] = 1'b1;
        repeat (9) tick();
        ctrl_in[0] = 1'b0;
        ctrl_in[1] = 1'b1;
        tick();
        check("abort_clr_res", {res_hi, res_lo}, 32'h0);
        check("abort_clr_status", {16'h0, status}, 32'h0);
        ctrl_in[1] = 1'b0;
        repeat (25) tick();
        check("abort_clr_nodone", {16'h0, status}, 32'h0);
        check("abort_clr_res2", {res_hi, res_lo}, 32'h0);
        model_zero();

        // Reset pulse at MUL cycle 8; start stays high across reset
        run_op(16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        ctrl_in[0] = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0;
        #2;
        check("abort_rst_lo", {16'h0, res_lo}, 32'h0);
        check("abort_rst_hi", {16'h0, res_hi}, 32'h0);
        check("abort_rst_status", {16'h0, status}, 32'h0);
        #2;
        rst_n = 1'b1;
        repeat (25) tick();
        check("rst_no_restart", {16'h0, status}, 32'h0);
        check("rst_res_zero", {res_hi, res_lo}, 32'h0);
        ctrl_in[0] = 1'b0;
        tick();
        model_zero();

        // Start and clear edges together in IDLE
        run_op(16'd5, 16'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        ctrl_in[1:0] = 2'b11;
        tick();
        check("both_res", {res_hi, res_lo}, 32'h0);
        check("both_status", {16'h0, status}, 32'h0);
        repeat (20) tick();
        check("both_idle", {16'h0, status}, 32'h0);
        ctrl_in[1:0] = 2'b00;
        tick();
        model_zero();

        // op_count wraps 255 -> 0
        for (int i = 0; i < 256; i++) begin
            run_op(16'(i), 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("cnt_wrap", {24'h0, status[15:8]}, 32'h0);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
